// File: rtl/pbas_pkg.sv
// Shared definitions for the pipelined-divider scheduler: FSM encoding and the
// divider latency also used by the learning-rate datapath.
package pbas_pkg;

  localparam int unsigned DIV_LAT_DEFAULT = 34;

  typedef enum logic [1:0] {
    StRun,
    StDrain,
    StDone
  } state_e;

endpackage

// File: rtl/pbas_div_sched_if.sv
// Request, divider and response signals of the divider scheduler.
// The slave modport is the scheduler; master is its environment.
interface pbas_div_sched_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned N_REQ  = 2
);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ*DATA_W-1:0] req_dividend;
  logic [N_REQ*DATA_W-1:0] req_divisor;
  logic [DATA_W-1:0]       div_dividend;
  logic [DATA_W-1:0]       div_divisor;
  logic [DATA_W-1:0]       div_quotient;
  logic [DATA_W-1:0]       div_fractional;
  logic [N_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]       rsp_quotient;
  logic [DATA_W-1:0]       rsp_fractional;
  logic                    rsp_div0;
  logic                    flush_req;
  logic                    flush_done;
  logic                    busy;

  modport slave (
    input  req_valid, req_dividend, req_divisor, div_quotient, div_fractional, flush_req,
    output req_ready, div_dividend, div_divisor, rsp_valid, rsp_quotient, rsp_fractional,
           rsp_div0, flush_done, busy
  );

  modport master (
    output req_valid, req_dividend, req_divisor, div_quotient, div_fractional, flush_req,
    input  req_ready, div_dividend, div_divisor, rsp_valid, rsp_quotient, rsp_fractional,
           rsp_div0, flush_done, busy
  );

endinterface

// File: rtl/rr_arb.sv
// Round-robin arbiter: one-hot grant to the first requester found when
// searching upward from the one after ptr.
module rr_arb #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt
);

  logic found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    // Outer loop walks priority order, inner loop keeps bit indices constant.
    for (int k = 0; k < int'(N_REQ); k++) begin
      for (int i = 0; i < int'(N_REQ); i++) begin
        if (!found && req[i] && ((int'(ptr) + 1 + k) % int'(N_REQ)) == i) begin
          gnt[i] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pbas_div_sched.sv
// Shares one external pipelined divider among N_REQ requesters; a tag pipe
// matched to the divider latency routes each result back to its owner.
module pbas_div_sched
  import pbas_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned N_REQ   = 2,
  parameter int unsigned DIV_LAT = DIV_LAT_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  pbas_div_sched_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(N_REQ);
  localparam int unsigned CNT_W = $clog2(DIV_LAT + 2);

  state_e            state_q, state_d;
  logic              pulsed_q;
  logic              grant_en;
  logic              done_pulse;
  logic              transfer;
  logic              rsp_any;
  logic [N_REQ-1:0]  gnt;
  logic [PTR_W-1:0]  ptr_q;
  logic [PTR_W-1:0]  gnt_idx;
  logic [DATA_W-1:0] sel_dividend, sel_divisor;
  logic [DATA_W-1:0] dividend_q, divisor_q;
  logic [DIV_LAT:0]  vld_q, div0_q;
  logic [N_REQ-1:0]  id_q [DIV_LAT+1];
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  rr_arb #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_arb (
    .req (bus.req_valid),
    .ptr (ptr_q),
    .gnt (gnt)
  );

  always_comb begin
    gnt_idx      = '0;
    sel_dividend = '0;
    sel_divisor  = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (gnt[i]) begin
        gnt_idx      = PTR_W'(i);
        sel_dividend = bus.req_dividend[i*DATA_W +: DATA_W];
        sel_divisor  = bus.req_divisor[i*DATA_W +: DATA_W];
      end
    end
  end

  assign transfer = grant_en & (|gnt);
  assign rsp_any  = vld_q[DIV_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= PTR_W'(N_REQ - 1);
      dividend_q <= '0;
      divisor_q  <= '0;
    end else if (transfer) begin
      ptr_q      <= gnt_idx;
      dividend_q <= sel_dividend;
      divisor_q  <= sel_divisor;
    end
  end

  // Tag pipe: stage 0 lines up with the operand register, last stage with the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      div0_q <= '0;
      for (int i = 0; i <= int'(DIV_LAT); i++) begin
        id_q[i] <= '0;
      end
    end else begin
      vld_q   <= {vld_q[DIV_LAT-1:0], transfer};
      div0_q  <= {div0_q[DIV_LAT-1:0], transfer & (sel_divisor == '0)};
      id_q[0] <= transfer ? gnt : '0;
      for (int i = 1; i <= int'(DIV_LAT); i++) begin
        id_q[i] <= id_q[i-1];
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (transfer && !rsp_any) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!transfer && rsp_any) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // FSM: state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StRun;
      pulsed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pulsed_q <= (state_q == StDone);
    end
  end

  // FSM: next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:   if (bus.flush_req) state_d = StDrain;
      StDrain: if (cnt_q == '0)   state_d = StDone;
      StDone:  if (!bus.flush_req) state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  // FSM: outputs. The flush request blocks grants in the very cycle it is seen.
  always_comb begin
    grant_en   = (state_q == StRun) && !bus.flush_req;
    done_pulse = (state_q == StDone) && !pulsed_q;
  end

  assign bus.req_ready      = grant_en ? gnt : '0;
  assign bus.div_dividend   = dividend_q;
  assign bus.div_divisor    = divisor_q;
  assign bus.rsp_valid      = rsp_any ? id_q[DIV_LAT] : '0;
  assign bus.rsp_div0       = rsp_any & div0_q[DIV_LAT];
  assign bus.rsp_quotient   = bus.div_quotient;
  assign bus.rsp_fractional = bus.div_fractional;
  assign bus.flush_done     = done_pulse;
  assign bus.busy           = (cnt_q != '0);

endmodule

// File: tb/tb_pbas_div_sched.sv
// Randomised bench for pbas_div_sched with a behavioural divider, a
// round-robin/latency reference model and a response scoreboard.
module tb_pbas_div_sched;

  localparam int W   = 16;
  localparam int N   = 2;
  localparam int LAT = pbas_pkg::DIV_LAT_DEFAULT;

  typedef logic [N*W-1:0] ops_t;
  typedef struct {
    logic [N-1:0] id;
    logic [W-1:0] q;
    logic [W-1:0] f;
    logic         div0;
    int           cyc;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc      = 0;
  int   errors   = 0;
  int   checks   = 0;
  int   last_ptr = N - 1;
  int   fd_cycle = -1;
  exp_t sb[$];
  int   grants[$];
  logic [2*W-1:0] pipe [LAT];

  pbas_div_sched_if #(.DATA_W(W), .N_REQ(N)) bus ();

  pbas_div_sched #(
    .DATA_W  (W),
    .N_REQ   (N),
    .DIV_LAT (LAT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [2*W-1:0] ref_div(logic [W-1:0] a, logic [W-1:0] b);
    if (b == '0) return {{W{1'b1}}, a};
    return {a / b, a % b};
  endfunction

  // Behavioural divider: result appears LAT cycles after the operands.
  always @(posedge clk) begin
    pipe[0] <= ref_div(bus.div_dividend, bus.div_divisor);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.div_quotient   = pipe[LAT-1][2*W-1:W];
  assign bus.div_fractional = pipe[LAT-1][W-1:0];

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [N-1:0] rr_model(logic [N-1:0] v, int last);
    int vi;
    int idx;
    vi = int'(v);
    for (int k = 1; k <= N; k++) begin
      idx = (last + k) % N;
      if (((vi >> idx) & 1) != 0) return N'(1 << idx);
    end
    return '0;
  endfunction

  // An operation granted in cycle g keeps busy high in cycles g+1 .. g+LAT+1.
  function automatic bit busy_model(int k);
    foreach (grants[i]) if (grants[i] < k && k <= grants[i] + LAT + 1) return 1'b1;
    return 1'b0;
  endfunction

  function automatic ops_t rnd_ops(bit allow_zero);
    ops_t         o;
    logic [W-1:0] x;
    o = '0;
    for (int i = 0; i < N; i++) begin
      x = W'($urandom);
      if (allow_zero && $urandom_range(0, 7) == 0) x = '0;
      o = (o << W) | ops_t'(x);
    end
    return o;
  endfunction

  task automatic step(logic [N-1:0] v, ops_t dd, ops_t ds, logic flush, bit blocked);
    logic [N-1:0]   g;
    logic [W-1:0]   a, b;
    logic [2*W-1:0] r;
    exp_t           e;
    @(posedge clk);
    #1;
    bus.req_valid    = v;
    bus.req_dividend = dd;
    bus.req_divisor  = ds;
    bus.flush_req    = flush;
    @(negedge clk);
    g = blocked ? '0 : rr_model(v, last_ptr);
    check("req_ready", 64'(bus.req_ready), 64'(g));
    check("busy", 64'(bus.busy), 64'(busy_model(cyc)));
    check("flush_done", 64'(bus.flush_done), 64'(cyc == fd_cycle));
    for (int i = 0; i < N; i++) begin
      if (((int'(g) >> i) & 1) != 0) begin
        a      = W'(dd >> (i * W));
        b      = W'(ds >> (i * W));
        r      = ref_div(a, b);
        e.id   = g;
        e.q    = r[2*W-1:W];
        e.f    = r[W-1:0];
        e.div0 = (b == '0);
        e.cyc  = cyc + LAT + 1;
        sb.push_back(e);
        grants.push_back(cyc);
        last_ptr = i;
      end
    end
    while (grants.size() > 0 && grants[0] + LAT + 1 < cyc) void'(grants.pop_front());
  endtask

  task automatic idle(int n);
    repeat (n) step('0, '0, '0, 1'b0, 1'b0);
  endtask

  // Flush with whatever is in flight; flush_done is due one cycle after busy falls.
  task automatic do_flush();
    int f, lf;
    step(N'($urandom), rnd_ops(1), rnd_ops(1), 1'b1, 1'b1);
    f  = cyc;
    lf = (grants.size() > 0) ? grants[grants.size()-1] + LAT + 2 : 0;
    fd_cycle = ((f + 1 > lf) ? f + 1 : lf) + 1;
    while (cyc < fd_cycle + 2) step(N'($urandom), rnd_ops(1), rnd_ops(1), 1'b1, 1'b1);
    step(N'($urandom), rnd_ops(1), rnd_ops(1), 1'b0, 1'b1);
    fd_cycle = -1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.rsp_valid != '0) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", 64'(bus.rsp_valid), 64'(0));
        end else begin
          e = sb.pop_front();
          check("rsp_valid", 64'(bus.rsp_valid), 64'(e.id));
          check("rsp_cycle", 64'(cyc), 64'(e.cyc));
          check("rsp_quotient", 64'(bus.rsp_quotient), 64'(e.q));
          check("rsp_fractional", 64'(bus.rsp_fractional), 64'(e.f));
          check("rsp_div0", 64'(bus.rsp_div0), 64'(e.div0));
        end
      end else begin
        check("rsp_div0_idle", 64'(bus.rsp_div0), 64'(0));
      end
    end
  end

  initial begin
    bus.req_valid    = '0;
    bus.req_dividend = '0;
    bus.req_divisor  = '0;
    bus.flush_req    = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_div_dividend", 64'(bus.div_dividend), 64'(0));
    check("rst_div_divisor", 64'(bus.div_divisor), 64'(0));
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    check("rst_flush_done", 64'(bus.flush_done), 64'(0));

    // Contention from reset: grants 0,1,0,1.
    repeat (4) step(2'b11, rnd_ops(1), rnd_ops(1), 1'b0, 1'b0);
    idle(LAT + 4);
    // Single request 100/7, then zero divisor on requester 1.
    step(2'b01, {W'(0), W'(100)}, {W'(0), W'(7)}, 1'b0, 1'b0);
    idle(LAT + 4);
    step(2'b10, {W'(5), W'(0)}, {W'(0), W'(0)}, 1'b0, 1'b0);
    idle(LAT + 4);
    // Back-to-back grants to a lone requester, then flush with 3 in flight.
    repeat (3) step(2'b01, rnd_ops(1), rnd_ops(1), 1'b0, 1'b0);
    do_flush();
    // Random traffic with a second flush under load.
    repeat (300) step(N'($urandom), rnd_ops(1), rnd_ops(1), 1'b0, 1'b0);
    do_flush();
    repeat (100) step(N'($urandom), rnd_ops(1), rnd_ops(1), 1'b0, 1'b0);
    idle(LAT + 4);

    // Mid-flight reset after 5 grants: in-flight work is discarded.
    repeat (5) step(N'($urandom_range(1, 3)), rnd_ops(1), rnd_ops(1), 1'b0, 1'b0);
    idle(4);
    @(posedge clk);
    #1 rst_n = 1'b0;
    bus.req_valid = '0;
    sb.delete();
    grants.delete();
    last_ptr = N - 1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (40) begin
      step('0, '0, '0, 1'b0, 1'b0);
      check("rsp_after_reset", 64'(bus.rsp_valid), 64'(0));
    end

    repeat (30) step(N'($urandom), rnd_ops(1), rnd_ops(1), 1'b0, 1'b0);
    idle(LAT + 5);
    check("sb_drained", 64'(sb.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pbas_div_sched.md
PBAS_DIV_SCHED -- requirements
Module: pbas_div_sched

Interface
REQ-001 Parameter DATA_W, default 16, operand width of dividend and divisor.
REQ-002 Parameter N_REQ, default 2, number of requesters sharing the divider (2..8).
REQ-003 Parameter DIV_LAT, default 34, fixed latency of the external pipelined divider in cycles.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  N_REQ  per-requester operation request.
REQ-007 req_ready  output  N_REQ  one-hot grant; the operation transfers when req_valid[i] and req_ready[i] are both high.
REQ-008 req_dividend  input  N_REQ*DATA_W  packed dividends; requester i occupies slice i.
REQ-009 req_divisor  input  N_REQ*DATA_W  packed divisors; requester i occupies slice i.
REQ-010 div_dividend, div_divisor  output  DATA_W each  registered operands to the divider.
REQ-011 div_quotient, div_fractional  input  DATA_W each  divider results, valid DIV_LAT cycles after the operands.
REQ-012 rsp_valid  output  N_REQ  one-hot result strobe identifying the owner; no backpressure.
REQ-013 rsp_quotient, rsp_fractional  output  DATA_W each  result payload aligned with rsp_valid.
REQ-014 rsp_div0  output  1  high with rsp_valid when the originating divisor was zero.
REQ-015 flush_req  input  1  level request to stop granting and drain the pipeline.
REQ-016 flush_done  output  1  single-cycle pulse when a drain completes.
REQ-017 busy  output  1  high while any operation is in flight.

Function
REQ-018 Arbitration SHALL be round-robin: the search starts at the requester after the last granted one, and at most one grant is issued per cycle.
REQ-019 req_ready SHALL be combinational from req_valid and the round-robin pointer, and SHALL be zero in state DRAIN and state DONE.
REQ-020 On a transfer, div_dividend and div_divisor SHALL register the granted slices on the next edge, and the pointer SHALL advance to the granted index.
REQ-021 A tag shift register DIV_LAT+1 stages deep SHALL carry {valid, one-hot id, div0}; stage 0 is loaded alongside the operand register.
REQ-022 rsp_valid SHALL equal the tag valid ANDed with the id at the final stage, so total request-to-response latency is exactly DIV_LAT+1 cycles.
REQ-023 rsp_quotient and rsp_fractional SHALL pass through combinationally from the divider ports and are don't-care when rsp_valid is zero.
REQ-024 div0 SHALL be computed as divisor==0 at grant time; rsp_div0 SHALL be zero whenever rsp_valid is zero.
REQ-025 An in-flight counter of width clog2(DIV_LAT+2) SHALL increment on a grant and decrement on a response; on the same cycle it SHALL stay unchanged; busy SHALL equal counter!=0.
REQ-026 The FSM SHALL have three states: RUN (reset state), DRAIN and DONE.
REQ-027 RUN SHALL go to DRAIN when flush_req is high; a grant SHALL NOT be issued in that cycle.
REQ-028 DRAIN SHALL go to DONE when the counter is 0; in-flight responses continue to be delivered meanwhile.
REQ-029 DONE SHALL assert flush_done for 1 cycle, then go to RUN if flush_req is low, else stay in DONE with flush_done low.
REQ-030 Back-to-back grants to the same requester SHALL be allowed when it is the only one valid, giving a full throughput of 1 operation per cycle.

Reset
REQ-031 While rst_n is low, the following SHALL be held at zero: all tag stages, the counter, div_dividend, div_divisor, flush_done and busy, with the pointer at N_REQ-1 (so requester 0 wins first) and the FSM in RUN.
REQ-032 Reset asserted mid-operation SHALL discard all in-flight tags; stale divider outputs SHALL never produce rsp_valid.

Structure
REQ-033 Package pbas_pkg SHALL hold the FSM state encoding and the DIV_LAT default shared with the learning-rate datapath.
REQ-034 The round-robin arbiter SHALL be one sub-module, rr_arb (inputs req and pointer, output one-hot grant).
REQ-035 The divider itself SHALL remain outside this block.

Verification
REQ-036 Single request: requester 0 issues 100/7 at cycle 0 -> rsp_valid=01 at cycle 35, rsp_div0=0, busy high for cycles 1-35.
REQ-037 Contention: both requesters held valid for 4 cycles -> grants 0,1,0,1 and responses in the same order at cycles 35-38.
REQ-038 Zero divisor: requester 1 issues 5/0 -> rsp_valid=10 with rsp_div0=1 after 35 cycles.
REQ-039 Flush: flush_req raised with 3 operations in flight -> req_ready=0 throughout, all 3 responses delivered, flush_done single pulse one cycle after busy falls.
REQ-040 Mid-flight reset: rst_n low for 2 cycles at cycle 10 after 5 grants -> no rsp_valid for the following 40 cycles, counter=0.
